// File: rtl/mux_scan_pkg.sv
// Shared types for the mux_scan channel scanner: FSM state encoding and mode constants.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MANUAL  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DWELL   = 2'd3
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_mux_n_1.sv
// Combinational N_CH:1 selector of W-bit channels; out-of-range selects yield zero.
module mux_n_1 #(
  parameter  int N_CH  = 16,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) out = in[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Channel scanner: manual select or automatic round-robin scan with dwell, registered
// valid/ready output. Optional channel mask enabled by defining MUX_SCAN_MASK_EN.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH    = 16,
  parameter  int W       = 1,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*W-1:0]  in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]    ch_mask,
`endif
  input  logic               out_ready,
  output logic [W-1:0]       out,
  output logic [SEL_W-1:0]   ch,
  output logic               out_valid,
  output logic               wrap,
  output logic [1:0]         state_dbg
);

  // Handshake: a sample transfers on a cycle where out_valid && out_ready; while
  // out_valid is high and out_ready low, out/ch/out_valid are held unchanged.

  state_e             state_q, state_d;
  logic [W-1:0]       out_q, out_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               out_valid_q, out_valid_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               stop_pend_q, stop_pend_d;

  logic [N_CH-1:0]    mask_w;
  logic [SEL_W-1:0]   first_ch, next_ch, mux_sel;
  logic               has_any, above;
  logic [W-1:0]       mux_out;
  logic               hs, stalled, stop_eff, load;

`ifdef MUX_SCAN_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = '1;
`endif

  assign hs       = out_valid_q && out_ready;
  assign stalled  = out_valid_q && !out_ready;
  assign stop_eff = stop || stop_pend_q;

  // Lowest enabled channel, and the next enabled channel above ch (or wrap to lowest).
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_any  = 1'b0;
    above    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_w[i]) begin
        first_ch = SEL_W'(i);
        has_any  = 1'b1;
      end
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_w[i] && (SEL_W'(i) > ch_q)) begin
        next_ch = SEL_W'(i);
        above   = 1'b1;
      end
    end
    if (!above) next_ch = first_ch;
  end

  assign mux_sel = (state_q == ST_MANUAL) ? sel :
                   (state_q == ST_IDLE)   ? first_ch : next_ch;

  mux_n_1 #(.N_CH(N_CH), .W(W)) u_mux (
    .in  (in),
    .sel (mux_sel),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_MANUAL)                  state_d = ST_MANUAL;
        else if (start && !stop && has_any)       state_d = ST_PRESENT;
      end
      ST_MANUAL: begin
        if (mode == MODE_SCAN && !stalled)        state_d = ST_IDLE;
      end
      ST_PRESENT: begin
        if (out_valid_q) begin
          if (hs) begin
            if (stop_eff)                         state_d = ST_IDLE;
            else if (dwell != '0)                 state_d = ST_DWELL;
          end
        end else if (stop_eff || !has_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (stop_eff)                             state_d = ST_IDLE;
        else if (cnt_q <= DWELL_W'(1))            state_d = has_any ? ST_PRESENT : ST_IDLE;
      end
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; "load" captures a fresh sample from the selector.
  always_comb begin
    out_d       = out_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    stop_pend_d = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE:    load = (state_d == ST_PRESENT);
      ST_MANUAL: begin
        if (state_d == ST_IDLE)            out_valid_d = 1'b0;
        else if (!out_valid_q || out_ready) load = 1'b1;
      end
      ST_PRESENT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          cnt_d       = dwell;
        end else if (!out_valid_q && state_d == ST_PRESENT) begin
          load = 1'b1;
        end
      end
      ST_DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        load  = (state_d == ST_PRESENT);
      end
      default: ;
    endcase
    if (load) begin
      out_d       = mux_out;
      ch_d        = mux_sel;
      out_valid_d = 1'b1;
    end
    if (state_d == ST_PRESENT || state_d == ST_DWELL) stop_pend_d = stop_pend_q | stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign out       = out_q;
  assign ch        = ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = (state_q == ST_PRESENT) && hs && !above;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan (N_CH=16, W=1): manual, stall, scan, stop, reset, mask.
module tb_mux_scan;

  localparam int N_CH = 16;
  localparam int W = 1;
  localparam int DWELL_W = 8;
  localparam int SEL_W = 4;

  logic               clk;
  logic               rst_n;
  logic [N_CH*W-1:0]  in;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               start;
  logic               stop;
`ifdef MUX_SCAN_MASK_EN
  logic [N_CH-1:0]    ch_mask;
`endif
  logic               out_ready;
  logic [W-1:0]       out;
  logic [SEL_W-1:0]   ch;
  logic               out_valid;
  logic               wrap;
  logic [1:0]         state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  mux_scan #(.N_CH(N_CH), .W(W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .sel       (sel),
    .mode      (mode),
    .dwell     (dwell),
    .start     (start),
    .stop      (stop),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_ready (out_ready),
    .out       (out),
    .ch        (ch),
    .out_valid (out_valid),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = '0; sel = '0; mode = 1'b1; dwell = '0;
    start = 1'b0; stop = 1'b0; out_ready = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    ch_mask = '1;
`endif
    step();
    step();
    tests_run++;
    if ({out, ch, out_valid, wrap, state_dbg} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got out=%b ch=%0d valid=%b wrap=%b st=%0d, want all 0",
               out, ch, out_valid, wrap, state_dbg);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
  endtask

  task automatic test_manual();
    mode = 1'b0; out_ready = 1'b1;
    step();
    tests_run++;
    if (state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL manual_enter: got st=%0d, want 1", state_dbg);
    end
    for (int k = 0; k < N_CH; k++) begin
      in = 16'h0001 << k;
      sel = SEL_W'(k);
      step();
      tests_run++;
      if (out !== 1'b1 || ch !== SEL_W'(k) || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL manual_k%0d: got out=%b ch=%0d valid=%b, want 1/%0d/1", k, out, ch, out_valid, k);
      end
    end
  endtask

  task automatic test_stall();
    in = 16'h0008; sel = 4'd3; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel = SEL_W'(5 + i);
      in = '0;
      step();
      tests_run++;
      if (out !== 1'b1 || ch !== 4'd3 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got out=%b ch=%0d valid=%b, want 1/3/1", i, out, ch, out_valid);
      end
    end
    sel = 4'd9; in = 16'h0200; out_ready = 1'b1;
    step();
    tests_run++;
    if (out !== 1'b1 || ch !== 4'd9 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: got out=%b ch=%0d valid=%b, want 1/9/1", out, ch, out_valid);
    end
    mode = 1'b1;
    step();
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL manual_exit: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
  endtask

  task automatic test_scan();
    logic [N_CH-1:0] pat;
    pat = 16'hA5A5;
    in = pat; dwell = 8'd3; out_ready = 1'b1; mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s <= N_CH; s++) begin
      int c;
      c = s % N_CH;
      tests_run++;
      if (out_valid !== 1'b1 || ch !== SEL_W'(c) || out !== pat[c] || wrap !== (c == N_CH - 1)) begin
        tests_failed++;
        $display("FAIL scan_sample_%0d: got valid=%b ch=%0d out=%b wrap=%b, want 1/%0d/%b/%b",
                 s, out_valid, ch, out, wrap, c, pat[c], (c == N_CH - 1));
      end
      if (s < N_CH) begin
        for (int d = 0; d < 3; d++) begin
          step();
          tests_run++;
          if (out_valid !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL scan_dwell_%0d_%0d: got valid=%b wrap=%b, want 0/0", s, d, out_valid, wrap);
          end
        end
        step();
      end
    end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_in_dwell: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
  endtask

  task automatic test_start_stop();
    mode = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_stop_same: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
    out_ready = 1'b0; dwell = 8'd3; in = 16'h0001;
    start = 1'b1;
    step();
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    tests_run++;
    if (state_dbg !== 2'd2 || out_valid !== 1'b1 || ch !== 4'd0 || out !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_pending_stall: got st=%0d valid=%b ch=%0d out=%b, want 2/1/0/1",
               state_dbg, out_valid, ch, out);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_after_handshake: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
  endtask

  task automatic test_dwell_zero();
    dwell = 8'd0; in = 16'h0002; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests_run++;
    if (state_dbg !== 2'd2 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL dwell0_gap: got st=%0d valid=%b, want 2/0", state_dbg, out_valid);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || ch !== 4'd1 || out !== 1'b1) begin
      tests_failed++;
      $display("FAIL dwell0_next: got valid=%b ch=%0d out=%b, want 1/1/1", out_valid, ch, out);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL dwell0_stop: got st=%0d, want 0", state_dbg);
    end
  endtask

  task automatic test_reset_mid_scan();
    dwell = 8'd3; in = 16'h0080; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 28; i++) step();
    tests_run++;
    if (ch !== 4'd7 || out_valid !== 1'b1 || out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_scan_ch7: got ch=%0d valid=%b out=%b, want 7/1/1", ch, out_valid, out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out, ch, out_valid, wrap, state_dbg} !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: got out=%b ch=%0d valid=%b wrap=%b st=%0d, want all 0",
               out, ch, out_valid, wrap, state_dbg);
    end
    step();
    rst_n = 1'b1;
    in = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (ch !== 4'd0 || out_valid !== 1'b1 || out !== 1'b1 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL restart_after_reset: got ch=%0d valid=%b out=%b st=%0d, want 0/1/1/2",
               ch, out_valid, out, state_dbg);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    logic [SEL_W-1:0] exp_ch [4];
    exp_ch[0] = 4'd0; exp_ch[1] = 4'd4; exp_ch[2] = 4'd0; exp_ch[3] = 4'd4;
    ch_mask = 16'h0011; dwell = 8'd3; in = 16'h0010; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tests_run++;
      if (ch !== exp_ch[s] || out_valid !== 1'b1 || wrap !== (exp_ch[s] == 4'd4)) begin
        tests_failed++;
        $display("FAIL mask_seq_%0d: got ch=%0d valid=%b wrap=%b, want %0d/1/%b",
                 s, ch, out_valid, wrap, exp_ch[s], (exp_ch[s] == 4'd4));
      end
      if (s < 3) for (int d = 0; d < 4; d++) step();
    end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    ch_mask = '0; start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (state_dbg !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_zero_start: got st=%0d valid=%b, want 0/0", state_dbg, out_valid);
    end
    ch_mask = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_stall();
    test_scan();
    test_start_stop();
    test_dwell_zero();
    test_reset_mid_scan();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
